traffic_phase_controller: RTL and testbench



---
 rtl/traffic_phase_controller.sv | 167 ++++++++++++++++
 tb/tb_traffic_phase_controller.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: round-robin intersection controller with night, pedestrian and emergency modes.
// Define ADAPTIVE_GREEN_EN to stretch each green with the served phase's longest lane queue.
module traffic_phase_controller #(
   parameter int NUM_LANES = 8,
   parameter int CNT_W = 8,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 16,
   parameter int YELLOW_T = 2,
   parameter int ALLRED_T = 1,
   parameter int PED_T = 6,
   parameter int BLINK_T = 2,
   localparam int NP = NUM_LANES / 2,
   localparam int PW = $clog2(NP)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       timeSignal,
   input  logic                       pedSignal,
   input  logic                       emgSignal,
   input  logic [NUM_LANES-1:0]       emgLane,
   input  logic [NUM_LANES*CNT_W-1:0] laneCount,
   output logic [NUM_LANES-1:0]       trafficLightGreen,
   output logic [NUM_LANES-1:0]       trafficLightYellow,
   output logic [NUM_LANES-1:0]       walkingLightOutput,
   output logic [1:0]                 trafficMode,
   output logic [PW-1:0]              activePhase
);
   localparam int TW = $clog2(GREEN_MAX + GREEN_MIN + YELLOW_T + ALLRED_T + PED_T + BLINK_T + 1);

   typedef enum logic [2:0] {S_ALL_RED, S_GREEN, S_YELLOW, S_EMG_GREEN, S_PED_WALK, S_NIGHT} state_t;

   state_t               state_q, state_d;
   logic [TW-1:0]        timer_q, timer_d, glen;
   logic [PW-1:0]        phase_q, phase_d, emg_p, next_p, base_p;
   logic                 ped_q, ped_d, emgf_q, emgf_d, blink_q, blink_d, started_q, started_d;
   logic                 emg_v, enter;
   logic [NUM_LANES-1:0] green_q, green_d, yellow_q, yellow_d, walk_q, walk_d, mask;
   logic [1:0]           mode_q, mode_d;
   logic [NP-1:0]        busy;
   logic [CNT_W-1:0]     lane_cnt [NUM_LANES];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_cnt
      assign lane_cnt[i] = laneCount[i*CNT_W +: CNT_W];
   end

   // Lowest emgLane bit picks the phase; the next green is the first busy phase after base_p.
   always_comb begin
      emg_p = '0;
      for (int i = NUM_LANES - 1; i >= 0; i--)
         if (emgLane[i]) emg_p = PW'(i / 2);
      emg_v = emgSignal && |emgLane;
      for (int p = 0; p < NP; p++)
         busy[p] = |lane_cnt[2*p] || |lane_cnt[2*p+1];
      base_p = started_q ? phase_q : PW'(NP - 1);
      next_p = PW'((int'(base_p) + 1) % NP);
      for (int k = NP; k >= 1; k--)
         if (busy[PW'((int'(base_p) + k) % NP)]) next_p = PW'((int'(base_p) + k) % NP);
   end

`ifdef ADAPTIVE_GREEN_EN
   logic [TW-1:0]    glen_q, glen_d;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic [CNT_W:0]   glen_sum;
   always_comb begin
      cnt_a = lane_cnt[{next_p, 1'b0}];
      cnt_b = lane_cnt[{next_p, 1'b1}];
      glen_sum = {1'b0, (cnt_a > cnt_b ? cnt_a : cnt_b) >> 2} + (CNT_W+1)'(GREEN_MIN);
      glen_d = (state_d == S_GREEN && state_q != S_GREEN)
         ? (int'(glen_sum) > GREEN_MAX ? TW'(GREEN_MAX) : TW'(glen_sum)) : glen_q;
   end
   always_ff @(posedge clk) begin
      if (rst) glen_q <= TW'(GREEN_MIN);
      else     glen_q <= glen_d;
   end
   assign glen = glen_q;
`else
   assign glen = TW'(GREEN_MIN);
`endif

   // emgf marks a YELLOW/ALL_RED that an emergency caused, so it reports mode 11.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      emgf_d = emgf_q;
      case (state_q)
         S_ALL_RED: if (timer_q == TW'(ALLRED_T - 1)) begin
            emgf_d = 1'b0;
            if (emg_v) begin
               state_d = S_EMG_GREEN;
               phase_d = emg_p;
            end else if (timeSignal) state_d = S_NIGHT;
            else if (ped_q) state_d = S_PED_WALK;
            else begin
               state_d = S_GREEN;
               phase_d = next_p;
            end
         end
         S_GREEN: if (emg_v && emg_p == phase_q) state_d = S_EMG_GREEN;
         else if (emg_v || timer_q == glen - TW'(1)) begin
            state_d = S_YELLOW;
            emgf_d = emg_v;
         end
         S_YELLOW: if (timer_q == TW'(YELLOW_T - 1)) state_d = S_ALL_RED;
         S_EMG_GREEN: if (!emg_v || emg_p != phase_q) begin
            state_d = S_YELLOW;
            emgf_d = 1'b1;
         end
         S_PED_WALK: if (timer_q == TW'(PED_T - 1)) state_d = S_ALL_RED;
         S_NIGHT: if (!timeSignal || emg_v) begin
            state_d = S_ALL_RED;
            emgf_d = emg_v;
         end
         default: state_d = S_ALL_RED;
      endcase
   end

   always_comb begin
      enter = state_d != state_q;
      timer_d = (enter || (state_q == S_NIGHT && timer_q == TW'(BLINK_T - 1))) ? '0 : timer_q + TW'(1);
      blink_d = (state_d == S_NIGHT && enter) ? 1'b1
         : (state_q == S_NIGHT && timer_q == TW'(BLINK_T - 1)) ? ~blink_q : blink_q;
      ped_d = (state_q == S_NIGHT || state_d == S_NIGHT) ? 1'b0
         : (ped_q && !(state_q == S_PED_WALK && enter)) || pedSignal;
      started_d = started_q || state_d == S_GREEN || state_d == S_EMG_GREEN;
      for (int i = 0; i < NUM_LANES; i++)
         mask[i] = PW'(i / 2) == phase_d;
      green_d = (state_d == S_GREEN || state_d == S_EMG_GREEN) ? mask : '0;
      yellow_d = state_d == S_YELLOW ? mask : state_d == S_NIGHT ? {NUM_LANES{blink_d}} : '0;
      walk_d = {NUM_LANES{state_d == S_PED_WALK}};
      mode_d = (state_d == S_EMG_GREEN || (emgf_d && (state_d == S_YELLOW || state_d == S_ALL_RED))) ? 2'b11
         : state_d == S_PED_WALK ? 2'b10 : state_d == S_NIGHT ? 2'b01 : 2'b00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_ALL_RED;
         timer_q   <= '0;
         phase_q   <= '0;
         ped_q     <= 1'b0;
         emgf_q    <= 1'b0;
         blink_q   <= 1'b0;
         started_q <= 1'b0;
         green_q   <= '0;
         yellow_q  <= '0;
         walk_q    <= '0;
         mode_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         phase_q   <= phase_d;
         ped_q     <= ped_d;
         emgf_q    <= emgf_d;
         blink_q   <= blink_d;
         started_q <= started_d;
         green_q   <= green_d;
         yellow_q  <= yellow_d;
         walk_q    <= walk_d;
         mode_q    <= mode_d;
      end
   end

   assign trafficLightGreen  = green_q;
   assign trafficLightYellow = yellow_q;
   assign walkingLightOutput = walk_q;
   assign trafficMode        = mode_q;
   assign activePhase        = phase_q;
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: directed cycle-by-cycle lamp checks for traffic_phase_controller.
module tb_traffic_phase_controller;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        timeSignal = 1'b0, pedSignal = 1'b0, emgSignal = 1'b0;
   logic [7:0]  emgLane = '0;
   logic [63:0] laneCount = {8{8'd5}};
   logic [7:0]  green, yellow, walk;
   logic [1:0]  mode, phase;
   int          checks = 0, errors = 0;

   traffic_phase_controller dut (
      .clk(clk), .rst(rst), .timeSignal(timeSignal), .pedSignal(pedSignal),
      .emgSignal(emgSignal), .emgLane(emgLane), .laneCount(laneCount),
      .trafficLightGreen(green), .trafficLightYellow(yellow), .walkingLightOutput(walk),
      .trafficMode(mode), .activePhase(phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input string tag, input logic [7:0] g, input logic [7:0] y, input logic [7:0] w,
                      input logic [1:0] m, input logic [1:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         check($sformatf("%s[%0d].green", tag, i), 32'(green), 32'(g));
         check($sformatf("%s[%0d].yellow", tag, i), 32'(yellow), 32'(y));
         check($sformatf("%s[%0d].walk", tag, i), 32'(walk), 32'(w));
         check($sformatf("%s[%0d].mode", tag, i), 32'(mode), 32'(m));
         check($sformatf("%s[%0d].phase", tag, i), 32'(phase), 32'(p));
      end
   endtask

   task automatic do_reset(input logic [63:0] counts);
      rst = 1'b1;
      timeSignal = 1'b0;
      pedSignal = 1'b0;
      emgSignal = 1'b0;
      emgLane = '0;
      laneCount = counts;
      run("reset", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 2);
      rst = 1'b0;
   endtask

   initial begin
      // Plain rotation 0->1->2->3->0, G4/Y2/R1.
      do_reset({8{8'd5}});
      run("g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);
      run("y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 4);
      run("y1", 8'h00, 8'h0C, 8'h00, 2'b00, 2'd1, 2);
      run("r1", 8'h00, 8'h00, 8'h00, 2'b00, 2'd1, 1);
      run("g2", 8'h30, 8'h00, 8'h00, 2'b00, 2'd2, 4);
      run("y2", 8'h00, 8'h30, 8'h00, 2'b00, 2'd2, 2);
      run("r2", 8'h00, 8'h00, 8'h00, 2'b00, 2'd2, 1);
      run("g3", 8'hC0, 8'h00, 8'h00, 2'b00, 2'd3, 4);
      run("y3", 8'h00, 8'hC0, 8'h00, 2'b00, 2'd3, 2);
      run("r3", 8'h00, 8'h00, 8'h00, 2'b00, 2'd3, 1);
      run("g0b", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);

      // Empty phases 1 and 2 are skipped.
      do_reset({8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd5});
      run("skip.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);
      run("skip.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("skip.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("skip.g3", 8'hC0, 8'h00, 8'h00, 2'b00, 2'd3, 4);
      run("skip.y3", 8'h00, 8'hC0, 8'h00, 2'b00, 2'd3, 2);
      run("skip.r3", 8'h00, 8'h00, 8'h00, 2'b00, 2'd3, 1);
      run("skip.g0b", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);

      // One-cycle pedestrian pulse during green.
      do_reset({8{8'd5}});
      run("ped.g0a", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      pedSignal = 1'b1;
      run("ped.g0b", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      pedSignal = 1'b0;
      run("ped.g0c", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 2);
      run("ped.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("ped.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("ped.walk", 8'h00, 8'h00, 8'hFF, 2'b10, 2'd0, 6);
      run("ped.r1", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("ped.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 4);

      // Emergency for phase 2 interrupts phase 0 green.
      do_reset({8{8'd5}});
      run("emg.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      emgSignal = 1'b1;
      emgLane = 8'b0010_0000;
      run("emg.y0", 8'h00, 8'h03, 8'h00, 2'b11, 2'd0, 2);
      run("emg.r0", 8'h00, 8'h00, 8'h00, 2'b11, 2'd0, 1);
      run("emg.g2", 8'h30, 8'h00, 8'h00, 2'b11, 2'd2, 5);
      emgSignal = 1'b0;
      run("emg.y2", 8'h00, 8'h30, 8'h00, 2'b11, 2'd2, 2);
      run("emg.r2", 8'h00, 8'h00, 8'h00, 2'b11, 2'd2, 1);
      run("emg.g3", 8'hC0, 8'h00, 8'h00, 2'b00, 2'd3, 4);

      // Night flashing; pedestrian requests during night are dropped.
      do_reset({8{8'd5}});
      run("night.g0a", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      timeSignal = 1'b1;
      run("night.g0b", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 3);
      run("night.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("night.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("night.on1", 8'h00, 8'hFF, 8'h00, 2'b01, 2'd0, 2);
      pedSignal = 1'b1;
      run("night.off", 8'h00, 8'h00, 8'h00, 2'b01, 2'd0, 2);
      pedSignal = 1'b0;
      run("night.on2", 8'h00, 8'hFF, 8'h00, 2'b01, 2'd0, 2);
      timeSignal = 1'b0;
      run("night.r1", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("night.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 4);

      // Reset in the middle of phase 1 yellow.
      do_reset({8{8'd5}});
      run("rm.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);
      run("rm.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("rm.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("rm.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 4);
      run("rm.y1", 8'h00, 8'h0C, 8'h00, 2'b00, 2'd1, 1);
      rst = 1'b1;
      run("rm.rst", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      rst = 1'b0;
      run("rm.g0b", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 1);

      // emgLane=0 ignored; same-phase emergency keeps green; lane change re-pre-empts.
      do_reset({8{8'd5}});
      emgSignal = 1'b1;
      run("ez.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);
      run("ez.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("ez.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("ez.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 1);
      emgLane = 8'b0000_1000;
      run("es.g1", 8'h0C, 8'h00, 8'h00, 2'b11, 2'd1, 7);
      emgLane = 8'b0000_0001;
      run("es.y1", 8'h00, 8'h0C, 8'h00, 2'b11, 2'd1, 2);
      run("es.r1", 8'h00, 8'h00, 8'h00, 2'b11, 2'd1, 1);
      run("es.g0", 8'h03, 8'h00, 8'h00, 2'b11, 2'd0, 2);
      emgSignal = 1'b0;
      run("es.y0", 8'h00, 8'h03, 8'h00, 2'b11, 2'd0, 2);
      run("es.r0", 8'h00, 8'h00, 8'h00, 2'b11, 2'd0, 1);
      run("es.g1b", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 1);

      // Green length versus queue: phase 0 max 40, phase 1 max 255.
      do_reset({8'd5, 8'd5, 8'd5, 8'd5, 8'd0, 8'd255, 8'd3, 8'd40});
`ifdef ADAPTIVE_GREEN_EN
      run("ad.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 14);
      run("ad.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("ad.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("ad.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 16);
      run("ad.y1", 8'h00, 8'h0C, 8'h00, 2'b00, 2'd1, 1);
`else
      run("ad.g0", 8'h03, 8'h00, 8'h00, 2'b00, 2'd0, 4);
      run("ad.y0", 8'h00, 8'h03, 8'h00, 2'b00, 2'd0, 2);
      run("ad.r0", 8'h00, 8'h00, 8'h00, 2'b00, 2'd0, 1);
      run("ad.g1", 8'h0C, 8'h00, 8'h00, 2'b00, 2'd1, 4);
      run("ad.y1", 8'h00, 8'h0C, 8'h00, 2'b00, 2'd1, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
